// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token symbols (common with the encoder)
// and the word-alignment FSM state encoding.
package tmds_pkg;

  // Control tokens sent during blanking, indexed by their 2-bit value.
  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  // Word-alignment FSM states.
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_LOCKED = 2'd2
  } tmds_state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational 10b->8b TMDS symbol decode plus control-token recognition.
// Only exact matches against the four tokens count as control symbols.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] i_sym,
  output logic [7:0] o_data,
  output logic       o_is_ctrl,
  output logic [1:0] o_ctrl
);

  logic [7:0] w_d;

  // Undo the optional inversion signalled by bit 9.
  assign w_d = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];

  // Undo the XOR (bit 8 = 1) or XNOR (bit 8 = 0) transition chain.
  always_comb begin
    o_data    = 8'h00;
    o_data[0] = w_d[0];
    for (int i = 1; i < 8; i++) begin
      o_data[i] = i_sym[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
    end
  end

  // Exact match against the control-token table.
  always_comb begin
    o_is_ctrl = 1'b1;
    o_ctrl    = 2'b00;
    case (i_sym)
      CTRL_TOKEN_00: o_ctrl = 2'b00;
      CTRL_TOKEN_01: o_ctrl = 2'b01;
      CTRL_TOKEN_10: o_ctrl = 2'b10;
      CTRL_TOKEN_11: o_ctrl = 2'b11;
      default:       o_is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder with word-boundary search.
// Stage 1 registers the decoded symbol and token flags; the alignment FSM
// works on the stage-1 flags; stage 2 registers DATA/CTRL/VDE, gated by lock.
// BITSLIP is a combinational pulse from registered state: it is high only
// during the final SEARCH cycle before the move to SLIP, so it never overlaps
// SLIP or LOCKED.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN       = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int SLIP_WAIT      = 16,
  parameter int MAX_GAP        = 4095
) (
  input  logic        PIXCLK,
  input  logic        RST_N,
  input  logic [9:0]  TMDSencDATA,
  output logic [7:0]  DATA,
  output logic [1:0]  CTRL,
  output logic        VDE,
  output logic        LOCKED,
  output logic        BITSLIP,
  output tmds_state_e o_dbg_state
);

  localparam int MAX_AB = (CTRL_RUN > SEARCH_TIMEOUT) ? CTRL_RUN : SEARCH_TIMEOUT;
  localparam int MAX_CD = (SLIP_WAIT > MAX_GAP) ? SLIP_WAIT : MAX_GAP;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXP + 1);

  logic [7:0]  w_data;
  logic        w_is_ctrl;
  logic [1:0]  w_ctrl;
  logic [7:0]  r_data1;
  logic        r_is_ctrl1;
  logic [1:0]  r_ctrl1;
  tmds_state_e r_state;
  tmds_state_e w_next;
  logic [CW-1:0] r_run;
  logic [CW-1:0] r_timer;
  logic [CW-1:0] w_run_nxt;
  logic [CW-1:0] w_timer_nxt;
  logic        w_bitslip;

  tmds_symbol_decode u_dec (
    .i_sym     (TMDSencDATA),
    .o_data    (w_data),
    .o_is_ctrl (w_is_ctrl),
    .o_ctrl    (w_ctrl)
  );

  // Stage 1: capture the decoded symbol and its token classification.
  always_ff @(posedge PIXCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_data1    <= 8'h00;
      r_is_ctrl1 <= 1'b0;
      r_ctrl1    <= 2'b00;
    end else begin
      r_data1    <= w_data;
      r_is_ctrl1 <= w_is_ctrl;
      r_ctrl1    <= w_ctrl;
    end
  end

  // Alignment FSM state and counter registers.
  always_ff @(posedge PIXCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_SEARCH;
      r_run   <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      r_run   <= w_run_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next-state logic; r_timer doubles as the gap counter while locked.
  always_comb begin
    w_next      = r_state;
    w_run_nxt   = r_run;
    w_timer_nxt = r_timer;
    w_bitslip   = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        w_timer_nxt = r_timer + 1'b1;
        w_run_nxt   = r_is_ctrl1 ? r_run + 1'b1 : '0;
        if (r_is_ctrl1 && (r_run == CW'(CTRL_RUN - 1))) begin
          w_next      = ST_LOCKED;
          w_run_nxt   = '0;
          w_timer_nxt = '0;
        end else if (r_timer == CW'(SEARCH_TIMEOUT - 1)) begin
          w_bitslip   = 1'b1;
          w_next      = ST_SLIP;
          w_run_nxt   = '0;
          w_timer_nxt = '0;
        end
      end
      ST_SLIP: begin
        if (r_timer == CW'(SLIP_WAIT - 1)) begin
          w_next      = ST_SEARCH;
          w_run_nxt   = '0;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (r_is_ctrl1) begin
          w_timer_nxt = '0;
        end else if (r_timer == CW'(MAX_GAP - 1)) begin
          w_next      = ST_SEARCH;
          w_run_nxt   = '0;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: begin
        w_next      = ST_SEARCH;
        w_run_nxt   = '0;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Stage 2: decoded outputs, forced to idle whenever not locked.
  always_ff @(posedge PIXCLK or negedge RST_N) begin
    if (!RST_N) begin
      DATA <= 8'h00;
      CTRL <= 2'b00;
      VDE  <= 1'b0;
    end else if (r_state != ST_LOCKED) begin
      DATA <= 8'h00;
      CTRL <= 2'b00;
      VDE  <= 1'b0;
    end else if (r_is_ctrl1) begin
      DATA <= 8'h00;
      CTRL <= r_ctrl1;
      VDE  <= 1'b0;
    end else begin
      DATA <= r_data1;
      VDE  <= 1'b1;
    end
  end

  assign LOCKED      = (r_state == ST_LOCKED);
  assign BITSLIP     = w_bitslip;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, so a symbol driven before edge N appears on DATA/CTRL/VDE after
// edge N+1.
module tb_tmds_decoder;
  import tmds_pkg::*;

  logic        PIXCLK = 1'b0;
  logic        RST_N;
  logic [9:0]  TMDSencDATA;
  logic [7:0]  DATA;
  logic [1:0]  CTRL;
  logic        VDE;
  logic        LOCKED;
  logic        BITSLIP;
  tmds_state_e dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int disp    = 0;

  tmds_decoder dut (
    .PIXCLK      (PIXCLK),
    .RST_N       (RST_N),
    .TMDSencDATA (TMDSencDATA),
    .DATA        (DATA),
    .CTRL        (CTRL),
    .VDE         (VDE),
    .LOCKED      (LOCKED),
    .BITSLIP     (BITSLIP),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 PIXCLK = ~PIXCLK;

  task automatic do_reset();
    RST_N       = 1'b0;
    TMDSencDATA = 10'h000;
    repeat (2) @(posedge PIXCLK);
    #1;
    RST_N = 1'b1;
  endtask

  // Driver: present one symbol for one clock edge.
  task automatic drive(input logic [9:0] s);
    TMDSencDATA = s;
    @(posedge PIXCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ctrl_tok(input logic [1:0] c);
    case (c)
      2'b00:   return CTRL_TOKEN_00;
      2'b01:   return CTRL_TOKEN_01;
      2'b10:   return CTRL_TOKEN_10;
      default: return CTRL_TOKEN_11;
    endcase
  endfunction

  // Reference TMDS data encoder (DVI algorithm) with running disparity.
  function automatic logic [9:0] tmds_enc(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] o;
    int n1d, n1q, n0q;
    n1d = $countones(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      o[9]   = ~qm[8];
      o[8]   = qm[8];
      o[7:0] = qm[8] ? qm[7:0] : ~qm[7:0];
      disp   = qm[8] ? disp + n1q - n0q : disp + n0q - n1q;
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      o    = {1'b1, qm[8], ~qm[7:0]};
      disp = disp + (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      o    = {1'b0, qm[8], qm[7:0]};
      disp = disp - (qm[8] ? 0 : 2) + n1q - n0q;
    end
    return o;
  endfunction

  initial begin
    logic [10:0] exp_q[$];
    logic [1:0]  last_ctrl;
    logic [9:0]  tok0;
    logic [9:0]  cur;
    int slip_at, lock_at, n_slips;

    tok0 = CTRL_TOKEN_00;

    // Reset state
    RST_N       = 1'b0;
    TMDSencDATA = 10'h000;
    #2;
    check("rst_outs", {DATA, CTRL, VDE, LOCKED, BITSLIP}, 13'h0);
    do_reset();
    check("rst_state", dbg_state, ST_SEARCH);

    // 7 tokens, data, 7 tokens, data: never locks
    repeat (7) drive(tok0);
    drive(10'h100);
    repeat (7) drive(tok0);
    drive(10'h100);
    drive(10'h100);
    check("no_lock_broken_run", LOCKED, 1'b0);

    // 8 consecutive tokens: lock on the stage-2 edge after the 8th
    repeat (8) drive(tok0);
    check("not_locked_at_8th", LOCKED, 1'b0);
    drive(10'h100);
    check("locked_after_8th", LOCKED, 1'b1);
    check("token8_gated", {VDE, CTRL, DATA}, 11'h0);

    // Directed decode vectors
    drive(10'h200);
    check("dec_100", {VDE, DATA}, 9'h100);
    drive(CTRL_TOKEN_00);
    check("dec_200", {VDE, DATA}, 9'h1FF);
    drive(CTRL_TOKEN_01);
    check("ctrl_00", {VDE, CTRL, DATA}, 11'h000);
    drive(CTRL_TOKEN_10);
    check("ctrl_01", {VDE, CTRL, DATA}, 11'h100);
    drive(CTRL_TOKEN_11);
    check("ctrl_10", {VDE, CTRL, DATA}, 11'h200);
    drive(10'h100);
    check("ctrl_11", {VDE, CTRL, DATA}, 11'h300);
    drive(10'h200);
    check("ctrl_hold", {VDE, CTRL, DATA}, 11'h700);

    // Gap: 4094 data tokens then a control token keeps lock
    drive(tok0);
    repeat (4094) drive(10'h100);
    drive(tok0);
    repeat (3) drive(10'h100);
    check("gap_4094_held", LOCKED, 1'b1);

    // Gap: 4095 data tokens drops lock
    drive(tok0);
    repeat (4094) drive(10'h100);
    check("gap_pre_drop", LOCKED, 1'b1);
    drive(10'h100);
    drive(10'h100);
    check("gap_4095_drop", LOCKED, 1'b0);
    drive(10'h100);
    check("unlocked_outs", {VDE, CTRL, DATA}, 11'h0);

    // Relock, produce non-zero outputs, then asynchronous reset
    repeat (9) drive(tok0);
    check("relock", LOCKED, 1'b1);
    drive(CTRL_TOKEN_11);
    drive(10'h200);
    drive(10'h200);
    check("pre_async", {VDE, CTRL, DATA}, 11'h7FF);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_outs", {DATA, CTRL, VDE, LOCKED, BITSLIP}, 13'h0);
    @(posedge PIXCLK);
    #1;
    RST_N = 1'b1;
    drive(10'h100);
    check("post_rst_search", dbg_state, ST_SEARCH);
    repeat (9) drive(tok0);
    check("reacquire", LOCKED, 1'b1);

    // Encoder->decoder loopback with random bytes and control periods
    last_ctrl = 2'b00;
    disp      = 0;
    for (int i = 0; i < 2000; i++) begin
      logic       v;
      logic [7:0] b;
      logic [1:0] c;
      logic [9:0] s;
      v = (i == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      b = 8'($urandom_range(0, 255));
      c = (i == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      if (v) begin
        s = tmds_enc(b);
        exp_q.push_back({1'b1, last_ctrl, b});
      end else begin
        s         = ctrl_tok(c);
        disp      = 0;
        last_ctrl = c;
        exp_q.push_back({1'b0, c, 8'h00});
      end
      drive(s);
      if (exp_q.size() >= 2) check("loopback", {VDE, CTRL, DATA}, exp_q.pop_front());
    end

    // Rotated stream: one slip at SEARCH cycle 1024, then lock after
    // 16 settle cycles plus 8 aligned tokens
    do_reset();
    cur     = {tok0[8:0], tok0[9]};
    slip_at = -1;
    lock_at = -1;
    n_slips = 0;
    for (int e = 1; e <= 1100 && lock_at < 0; e++) begin
      logic sl;
      sl = BITSLIP;
      TMDSencDATA = cur;
      @(posedge PIXCLK);
      #1;
      if (sl) cur = tok0;
      if (BITSLIP) begin
        n_slips++;
        if (slip_at < 0) slip_at = e;
      end
      if (LOCKED && lock_at < 0) lock_at = e;
    end
    check("slip_cycle", slip_at, 1023);
    check("slip_count", n_slips, 1);
    check("lock_after_slip", lock_at, 1048);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
